// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, instruction-format constants and the fetch FSM encoding.
package cpu_pkg;

    localparam int ADDR_WIDTH       = 8;
    localparam int DATA_WIDTH       = 8;
    localparam int OPERAND_FLAG_BIT = 7;

    localparam logic [DATA_WIDTH-1:0] HALT_OPCODE_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        FETCH_OP,
        FETCH_ARG,
        HOLD,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: walks the PC through memory, assembles 1/2-byte instructions and
// presents them to the decoder over valid/ready; honours redirects and stops on HALT.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 8'h00,
    parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_address,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_opcode,
    output logic [DATA_WIDTH-1:0] instr_operand,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  halted
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0] operand_q, operand_d;
    logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        ipc_d     = ipc_q;

        unique case (state_q)
            FETCH_OP: begin
                opcode_d  = mem_read_data;
                ipc_d     = pc_q;
                operand_d = '0;
                pc_d      = pc_q + ADDR_WIDTH'(1);
                state_d   = mem_read_data[OPERAND_FLAG_BIT] ? FETCH_ARG : HOLD;
            end
            FETCH_ARG: begin
                operand_d = mem_read_data;
                pc_d      = pc_q + ADDR_WIDTH'(1);
                state_d   = HOLD;
            end
            HOLD: begin
                if (instr_ready) begin
                    state_d = (opcode_q == HALT_OPCODE) ? HALTED : FETCH_OP;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: state_d = FETCH_OP;
        endcase

        // A redirect wins over every transition above, including the one into HALTED.
        if (redirect_valid) begin
            pc_d    = redirect_address;
            state_d = FETCH_OP;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FETCH_OP;
            pc_q      <= RESET_PC;
            opcode_q  <= '0;
            operand_q <= '0;
            ipc_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            ipc_q     <= ipc_d;
        end
    end

    assign mem_read_address = pc_q;
    assign instr_valid      = (state_q == HOLD);
    assign halted           = (state_q == HALTED);
    assign instr_opcode     = opcode_q;
    assign instr_operand    = operand_q;
    assign instr_pc         = ipc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized run, all checked
// every cycle against a latency-based reference model of the fetch stream.
module tb_instruction_fetch;

    logic       clock = 1'b0;
    logic       reset;
    logic       redirect_valid;
    logic [7:0] redirect_address;
    logic       instr_ready;
    logic [7:0] mem_read_address;
    logic [7:0] mem_read_data;
    logic       instr_valid;
    logic [7:0] instr_opcode;
    logic [7:0] instr_operand;
    logic [7:0] instr_pc;
    logic       halted;

    logic [7:0] mem [256];
    assign mem_read_data = mem[mem_read_address];

    always #5 clock = ~clock;

    instruction_fetch #(
        .RESET_PC   (8'h00),
        .HALT_OPCODE(8'h00)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .mem_read_address(mem_read_address),
        .mem_read_data   (mem_read_data),
        .redirect_valid  (redirect_valid),
        .redirect_address(redirect_address),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_opcode    (instr_opcode),
        .instr_operand   (instr_operand),
        .instr_pc        (instr_pc),
        .halted          (halted)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: an instruction starting at m_start becomes valid once
    // m_k has counted up to its length; the read address is always m_start + m_k.
    logic [7:0]  m_start;
    int          m_k;
    bit          m_halt;
    logic [23:0] hq[$];

    function automatic int ilen(input logic [7:0] a);
        return mem[a][7] ? 2 : 1;
    endfunction

    task automatic step(input bit rst, input bit rv, input logic [7:0] ra, input bit rdy,
                        input bit chk = 1'b1);
        bit         exp_valid;
        logic [7:0] ea;
        logic [7:0] a1;
        reset            = rst;
        redirect_valid   = rv;
        redirect_address = ra;
        instr_ready      = rdy;
        @(negedge clock);
        exp_valid = !m_halt && (m_k == ilen(m_start));
        ea        = m_start + 8'(m_k);
        a1        = m_start + 8'd1;
        if (chk) begin
            check("valid", 32'(instr_valid), 32'(exp_valid));
            check("halted", 32'(halted), 32'(m_halt));
            check("addr", 32'(mem_read_address), 32'(ea));
            if (exp_valid) begin
                check("opcode", 32'(instr_opcode), 32'(mem[m_start]));
                check("operand", 32'(instr_operand), (ilen(m_start) == 2) ? 32'(mem[a1]) : 32'h0);
                check("ipc", 32'(instr_pc), 32'(m_start));
            end
        end
        if (instr_valid && rdy && !rst) hq.push_back({instr_opcode, instr_operand, instr_pc});
        if (rst) begin
            m_start = 8'h00; m_k = 0; m_halt = 1'b0;
        end else if (rv) begin
            m_start = ra; m_k = 0; m_halt = 1'b0;
        end else if (!m_halt) begin
            if (m_k < ilen(m_start)) m_k++;
            else if (rdy) begin
                if (mem[m_start] == 8'h00) m_halt = 1'b1;
                else begin
                    m_start = m_start + 8'(ilen(m_start));
                    m_k = 0;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    logic [7:0] snap_op, snap_arg, snap_pc, snap_addr;

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_address = 8'h00; instr_ready = 1'b0;
        m_start = 8'h00; m_k = 0; m_halt = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h01;
        mem[0] = 8'h01; mem[1] = 8'h82; mem[2] = 8'h5A;

        // Reset and first instructions
        step(1, 0, 8'h00, 1, 0);
        step(1, 0, 8'h00, 1);
        check("rst_op", 32'(instr_opcode), 32'h0);
        check("rst_arg", 32'(instr_operand), 32'h0);
        check("rst_ipc", 32'(instr_pc), 32'h0);
        check("rst_addr", 32'(mem_read_address), 32'h0);
        hq.delete();
        repeat (5) step(0, 0, 8'h00, 1);
        check("rst_nhand", hq.size(), 2);
        if (hq.size() >= 2) begin
            check("rst_i0", 32'(hq[0]), 32'h010000);
            check("rst_i1", 32'(hq[1]), 32'h825A01);
        end
        check("rst_pc3", 32'(mem_read_address), 32'h03);

        // Backpressure
        step(0, 0, 8'h00, 0);
        snap_op = instr_opcode; snap_arg = instr_operand; snap_pc = instr_pc; snap_addr = mem_read_address;
        hq.delete();
        repeat (5) step(0, 0, 8'h00, 0);
        check("bp_stable", {8'h00, instr_opcode, instr_pc, mem_read_address},
              {8'h00, snap_op, snap_pc, snap_addr});
        check("bp_fields", {8'h00, snap_op, snap_arg, snap_pc}, 32'h00010003);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        check("bp_nhand", hq.size(), 1);

        // PC wrap
        mem[8'hFF] = 8'h90; mem[8'h00] = 8'h33; mem[8'h01] = 8'h01;
        step(0, 1, 8'hFF, 0);
        hq.delete();
        repeat (3) step(0, 0, 8'h00, 1);
        check("wrap_nhand", hq.size(), 1);
        if (hq.size() >= 1) check("wrap_i", 32'(hq[0]), 32'h9033FF);
        check("wrap_next", 32'(mem_read_address), 32'h01);
        step(0, 0, 8'h00, 0);

        // Redirect during the operand fetch
        mem[8'h10] = 8'h85; mem[8'h11] = 8'h22; mem[8'h40] = 8'h07; mem[8'h41] = 8'h01;
        step(0, 1, 8'h10, 0);
        step(0, 0, 8'h00, 0);
        step(0, 1, 8'h40, 0);
        hq.delete();
        step(0, 0, 8'h00, 0);
        check("mid_valid", 32'(instr_valid), 32'h1);
        check("mid_ipc", 32'(instr_pc), 32'h40);
        step(0, 0, 8'h00, 0);
        check("mid_nhand", hq.size(), 0);

        // Redirect together with a handshake in HOLD
        step(0, 1, 8'h10, 1);
        repeat (3) step(0, 0, 8'h00, 1);
        check("sim_nhand", hq.size(), 2);
        if (hq.size() >= 2) begin
            check("sim_i0", 32'(hq[0]), 32'h070040);
            check("sim_i1", 32'(hq[1]), 32'h852210);
        end

        // Reset together with redirect; then halt
        mem[8'h00] = 8'h00;
        step(1, 1, 8'h80, 1);
        check("rr_addr", 32'(mem_read_address), 32'h00);
        check("rr_valid", 32'(instr_valid), 32'h0);
        hq.delete();
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 1);
        repeat (10) step(0, 0, 8'h00, 1'($urandom_range(0, 1)));
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_nhand", hq.size(), 1);
        if (hq.size() >= 1) check("halt_i", 32'(hq[0]), 32'h000000);
        step(0, 1, 8'h10, 1);
        check("halt_clear", 32'(halted), 32'h0);
        repeat (4) step(0, 0, 8'h00, 1);

        // Randomized run
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 11) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        step(1, 0, 8'h00, 1, 0);
        for (int c = 0; c < 1500; c++) begin
            step(1'($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 11) == 0),
                 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 9) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage sitting directly downstream of the 8-bit `memory` block's read port and upstream of the decoder. It drives the memory read address from its program counter and samples the combinational read data. It assembles one- or two-byte instructions and hands them to the decoder over a valid/ready handshake. It accepts PC redirects (branches/jumps) and stops fetching after handing off a HALT instruction.

## Interface
- `RESET_PC`, 8'h00, PC value loaded on reset.
- `HALT_OPCODE`, 8'h00, opcode that halts fetch after hand-off. An all-zero memory therefore halts immediately.
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high; sampled on rising `clock`.
- `mem_read_address` output 8: always equals the current PC (combinational from the PC register).
- `mem_read_data` input 8: byte at `mem_read_address`, valid in the same cycle.
- `redirect_valid` input 1: load new PC this cycle.
- `redirect_address` input 8: target PC.
- `instr_valid` output 1: instruction fields are valid.
- `instr_ready` input 1: decoder accepts the instruction.
- `instr_opcode` output 8: opcode byte.
- `instr_operand` output 8: operand byte; 8'h00 for one-byte instructions.
- `instr_pc` output 8: address of the opcode byte.
- `halted` output 1: high while in HALTED.

## Operation
- Instruction format: `opcode[7]=1` means a two-byte instruction (opcode, operand). `opcode[7]=0` means a one-byte instruction.
- FSM states: FETCH_OP, FETCH_ARG, HOLD, HALTED.
- **FETCH_OP**
  - Latch `instr_opcode<=mem_read_data`, `instr_pc<=pc`, `instr_operand<=0`.
  - `pc<=pc+1`.
  - Go to FETCH_ARG if `mem_read_data[7]`, else HOLD.
- **FETCH_ARG**
  - Latch `instr_operand<=mem_read_data`; `pc<=pc+1`; go to HOLD.
- **HOLD**
  - `instr_valid=1`; fields stay stable until the handshake.
  - On `instr_ready`: go to HALTED if `instr_opcode==HALT_OPCODE`, else FETCH_OP.
- **HALTED**
  - `halted=1`, `instr_valid=0`, PC frozen.
  - Leave only via redirect or reset.
- PC arithmetic is 8-bit modulo: 8'hFF+1 = 8'h00.
  - A two-byte instruction at 8'hFF takes its operand from 8'h00.
- **Redirect** (`redirect_valid=1`, any state)
  - `pc<=redirect_address`, state goes to FETCH_OP; any partially fetched or held instruction is discarded.
  - If `instr_valid && instr_ready` in the same cycle, the handshake counts as completed (decoder owns that instruction); the redirect still applies.
  - Redirect overrides the HALT transition.
- **Reset** (highest priority, any state, including mid two-byte fetch)
  - `pc<=RESET_PC`, state FETCH_OP.
  - `instr_valid=0`, `halted=0`.
  - `instr_opcode`, `instr_operand`, `instr_pc` all 8'h00.
  - `mem_read_address=RESET_PC`.

## Timing
- `instr_valid` and `halted` are decoded from the registered state; no combinational path from any input to them.
- `mem_read_address` depends only on the PC register; no path from `mem_read_data`.
- One-byte instruction: valid 1 cycle after entering FETCH_OP.
- Two-byte instruction: valid 2 cycles after entering FETCH_OP.
- Peak throughput with `instr_ready` held high:
  - one-byte instruction every 2 cycles;
  - two-byte instruction every 3 cycles.
- Backpressure: HOLD persists indefinitely with fields stable; PC does not advance.
- Redirect: the opcode at the target is latched in the cycle after the redirect; `instr_valid` rises 2 cycles after the redirect (one-byte target).

## Structure
- Shared package `cpu_pkg` holds:
  - `fetch_state_t` enum (FETCH_OP, FETCH_ARG, HOLD, HALTED);
  - `ADDR_WIDTH=8`, `DATA_WIDTH=8`;
  - `OPERAND_FLAG_BIT=7`;
  - `HALT_OPCODE` default value.
- Single module, no sub-module. PC register, state register and output latches all live in one clocked process; next-state logic is combinational.

## Test plan
- **Reset**: assert reset with memory `[0]=8'h01, [1]=8'h82, [2]=8'h5A`, `instr_ready=1` → after reset release `mem_read_address=0`; instr (01,00,pc 0), then (82,5A,pc 1) on the expected cycles; PC reaches 3.
- **Backpressure**: `instr_ready=0` for 5 cycles in HOLD → fields and `mem_read_address` unchanged; single hand-off when ready rises.
- **Wrap**: redirect to 8'hFF with `[FF]=8'h90, [00]=8'h33` → instr (90,33,pc FF); next fetch at 8'h01.
- **Redirect mid-fetch**: redirect to 8'h40 during FETCH_ARG → partial instruction never becomes valid; next instr_pc=8'h40.
- **Halt**: `[0]=8'h00` → instr (00,00,pc 0) handed off; `halted=1` and `instr_valid` stays 0 for 10 cycles; redirect to 8'h10 clears `halted` and resumes.
- **Simultaneous events**: redirect together with a handshake in HOLD → exactly one hand-off counted, then fetch from the target. Reset asserted in the same cycle as a redirect → PC=RESET_PC.
